add16_vector_source: RTL
========================

# add16_vector_source

Self-test stimulus generator for the 16-bit adder. It emits a stream of {a, b, expected} vectors over a valid/ready handshake. The first four vectors are fixed corner cases; the rest come from two 16-bit LFSRs, with expected = (a + b) mod 2^16 computed in the block. It sits on the FPGA in front of the adder and a checker, and gives the on-chip equivalent of the file-driven simulation vector stream.

## Interface
- NUM_VECTORS, 256: total vectors per run, including the four corner vectors. Legal range 1..65535.
- SEED_A, 16'hACE1: LFSR A seed. A value of 0 is replaced by 16'h0001.
- SEED_B, 16'h1D2C: LFSR B seed. A value of 0 is replaced by 16'h0001.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- ready  in  1  consumer can accept the current vector.
- valid  out  1  a, b, expected and index hold a vector.
- a  out  16  operand A.
- b  out  16  operand B.
- expected  out  16  (a + b) mod 2^16; carry discarded.
- index  out  16  number of the vector presented, 0-based.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on start: load vector 0, set valid=1, index=0, busy=1, and reload both LFSRs from their seeds.
- Corner vectors by index:
  - 0: a=0000, b=0000, expected=0000.
  - 1: a=FFFF, b=0001, expected=0000.
  - 2: a=7FFF, b=0001, expected=8000.
  - 3: a=8000, b=8000, expected=0000.
- If NUM_VECTORS < 4, only the first NUM_VECTORS corner vectors are sent.
- From index 4 onward, a = LFSR A and b = LFSR B. Both LFSRs advance once per accepted LFSR vector.
- LFSR step, Galois right shift: next = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000).
- expected is registered together with a and b and is never a combinational function of the outputs.
- Handshake: a vector is accepted on a rising edge where valid && ready.
  - On acceptance of a non-last vector, the next vector appears on the following cycle with no bubble, and index increments.
  - While valid && !ready, a, b, expected and index are held stable.
- After the last vector (index = NUM_VECTORS-1) is accepted: valid=0, busy=0, done=1, state DONE. The data outputs keep the last vector.
- A start in DONE behaves exactly like a start in IDLE: done clears and the run begins again with identical vectors.
- A start in RUN is ignored.
- If start and acceptance of the last vector occur in the same cycle, the block goes to DONE and that start is ignored.

## Timing
- Reset (rst_n=0, asynchronous):
  - state = IDLE.
  - valid=0, busy=0, done=0, a=b=expected=index=0.
  - LFSRs reload their seeds.
- Reset takes effect immediately, including mid-run. The run is abandoned and no further vectors are emitted until a new start.
- Reset release is sampled at the next rising edge; no output changes on release.
- Latency: start sampled at edge N gives valid=1 with vector 0 after edge N. Vector 0 can be accepted at edge N+1.
- Throughput: one vector per cycle while ready is held high.
- A run of NUM_VECTORS vectors with ready held high: done rises after edge N+NUM_VECTORS.

## Test plan
- Reset then start with ready=1 and NUM_VECTORS=8:
  - vectors 0–3 match the corner list.
  - index 4: a=ACE1, b=1D2C, expected=CA0D.
  - index 5: a=E270, b=0E96, expected=F106.
  - done=1 one cycle after index 7 is accepted.
- Backpressure: hold ready=0 for 5 cycles at index 4. a, b, expected and index stay at ACE1/1D2C/CA0D/4 throughout. Then ready=1 gives index 5 with the values above.
- Start pulses during RUN: assert start at indices 2 and 5. No restart occurs and index continues monotonically to 7.
- Restart from DONE: start after completion reproduces an identical stream, starting at a=0000 with index 4 = ACE1/1D2C. done clears the cycle after start is sampled.
- Reset mid-run: drive rst_n=0 at index 5. All outputs go to 0 immediately. A new start gives index 0 and index 4 = ACE1/1D2C, confirming the LFSRs reloaded.
- NUM_VECTORS=2 with SEED_A=0: exactly two vectors, index 0 and 1 (corners), then done. A second build with NUM_VECTORS=5 gives a=0001 at index 4.

Source files
------------

// File: rtl/add16_vector_source.sv
// Self-test vector source for the 16-bit adder: four fixed corner vectors,
// then LFSR-driven operands, each with a registered (a + b) mod 2^16.
module add16_vector_source #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [15:0] SEED_A      = 16'hACE1,
    parameter logic [15:0] SEED_B      = 16'h1D2C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ready,
    output logic        valid,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [15:0] expected,
    output logic [15:0] index,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DW         = 16;
    localparam logic [DW-1:0] LAST_IDX   = DW'(NUM_VECTORS - 1);
    localparam logic [DW-1:0] TAPS       = 16'hB400;
    localparam logic [DW-1:0] SEED_A_EFF = (SEED_A == '0) ? DW'(1) : SEED_A;
    localparam logic [DW-1:0] SEED_B_EFF = (SEED_B == '0) ? DW'(1) : SEED_B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] expected_q, expected_d;
    logic [DW-1:0] index_q, index_d;
    logic [DW-1:0] lfsr_a_q, lfsr_a_d;
    logic [DW-1:0] lfsr_b_q, lfsr_b_d;
    logic          load;
    logic [DW-1:0] load_idx;

    // Galois right-shift step.
    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // The LFSR registers always hold the operands of the next LFSR vector;
    // they step when that vector is loaded into the output registers.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        a_d        = a_q;
        b_d        = b_q;
        expected_d = expected_q;
        index_d    = index_q;
        lfsr_a_d   = lfsr_a_q;
        lfsr_b_d   = lfsr_b_q;
        load       = 1'b0;
        load_idx   = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    lfsr_a_d = SEED_A_EFF;
                    lfsr_b_d = SEED_B_EFF;
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            RUN: begin
                if (valid_q && ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load     = 1'b1;
                        load_idx = index_q + DW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            index_d = load_idx;
            case (load_idx)
                16'd0: begin a_d = 16'h0000; b_d = 16'h0000; end
                16'd1: begin a_d = 16'hFFFF; b_d = 16'h0001; end
                16'd2: begin a_d = 16'h7FFF; b_d = 16'h0001; end
                16'd3: begin a_d = 16'h8000; b_d = 16'h8000; end
                default: begin
                    a_d      = lfsr_a_q;
                    b_d      = lfsr_b_q;
                    lfsr_a_d = lfsr_step(lfsr_a_q);
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                end
            endcase
            expected_d = a_d + b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            expected_q <= '0;
            index_q    <= '0;
            lfsr_a_q   <= SEED_A_EFF;
            lfsr_b_q   <= SEED_B_EFF;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a_q        <= a_d;
            b_q        <= b_d;
            expected_q <= expected_d;
            index_q    <= index_d;
            lfsr_a_q   <= lfsr_a_d;
            lfsr_b_q   <= lfsr_b_d;
        end
    end

    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign a        = a_q;
    assign b        = b_q;
    assign expected = expected_q;
    assign index    = index_q;

endmodule
